// File: rtl/debounce_toggle_gen.sv
// Button debouncer that turns each accepted press into a single-cycle toggle pulse.
// A 2-flop synchronizer feeds a 4-state FSM that requires DEBOUNCE_CYCLES stable samples.
module debounce_toggle_gen #(
    parameter int unsigned DEBOUNCE_CYCLES  = 4,
    parameter bit          PULSE_ON_RELEASE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic en,
    output logic t_out,
    output logic btn_level,
    output logic busy
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdleLow,
        StWaitHigh,
        StHigh,
        StWaitLow
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sync_q, s_q;
    logic            t_out_d, btn_level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 1'b0;
            s_q       <= 1'b0;
            state_q   <= StIdleLow;
            cnt_q     <= '0;
            t_out     <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            sync_q    <= btn_in;
            s_q       <= sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            t_out     <= t_out_d;
            btn_level <= btn_level_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        t_out_d     = 1'b0;
        btn_level_d = btn_level;
        unique case (state_q)
            StIdleLow: begin
                if (s_q) state_d = StWaitHigh;
            end
            StWaitHigh: begin
                if (!s_q) begin
                    state_d = StIdleLow;
                end else if (cnt_q == CntMax) begin
                    state_d     = StHigh;
                    btn_level_d = 1'b1;
                    t_out_d     = en;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHigh: begin
                if (!s_q) state_d = StWaitLow;
            end
            StWaitLow: begin
                if (s_q) begin
                    state_d = StHigh;
                end else if (cnt_q == CntMax) begin
                    state_d     = StIdleLow;
                    btn_level_d = 1'b0;
                    t_out_d     = en & PULSE_ON_RELEASE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdleLow;
        endcase
        // Each state entry starts a fresh stability count.
        if (state_d != state_q) cnt_d = '0;
    end

    assign busy = (state_q == StWaitHigh) || (state_q == StWaitLow);

endmodule
